pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder_pkg.sv | 23 ++
 rtl/pipelined_adder_if.sv | 33 +++
 rtl/pipelined_adder_add_slice.sv | 25 ++
 rtl/pipelined_adder.sv | 99 +++++++++
 tb/tb_pipelined_adder.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared constants, slice-width helper and stage register type for pipelined_adder.
package pipe_add_pkg;

  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefStages = 4;
  // Upper bound on WIDTH, so one packed stage type can serve every instance.
  localparam int unsigned MaxWidth  = 64;

  function automatic int unsigned slice_width(int unsigned width, int unsigned stages);
    return width / stages;
  endfunction

  // Operands travel alongside the partial sum until their slice is consumed.
  typedef struct packed {
    logic                v;
    logic                c;
    logic                msb_c;
    logic [MaxWidth-1:0] s;
    logic [MaxWidth-1:0] a;
    logic [MaxWidth-1:0] b;
  } stage_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder; ovf exists only with PIPE_ADD_OVF_EN.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_ADD_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef PIPE_ADD_OVF_EN
    , output ovf
`endif
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef PIPE_ADD_OVF_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/pipelined_adder_add_slice.sv
// Combinational ripple-carry adder for one pipeline slice; also exposes carry into its MSB.
module add_slice #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] i_a,
  input  logic [Width-1:0] i_b,
  input  logic             i_cin,
  output logic [Width-1:0] o_s,
  output logic             o_cout,
  output logic             o_cmsb
);
  logic w_carry;

  always_comb begin
    w_carry = i_cin;
    o_s     = '0;
    o_cmsb  = i_cin;
    for (int i = 0; i < int'(Width); i++) begin
      if (i == int'(Width) - 1) o_cmsb = w_carry;
      o_s[i]  = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_carry;
  end
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one SLICE-bit ripple per stage, global stall on back-pressure.
// Define PIPE_ADD_OVF_EN to add the registered signed-overflow output.
module pipelined_adder
  import pipe_add_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned STAGES = DefStages
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_adder_if.slave  bus
);
  localparam int unsigned Slice = slice_width(WIDTH, STAGES);

  if (STAGES == 0 || WIDTH > MaxWidth || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: unsupported WIDTH/STAGES combination");
  end

  stage_t           r_stage      [STAGES];
  stage_t           w_next       [STAGES];
  logic [WIDTH-1:0] w_a_src      [STAGES];
  logic [WIDTH-1:0] w_b_src      [STAGES];
  logic [WIDTH-1:0] w_s_src      [STAGES];
  logic             w_c_src      [STAGES];
  logic             w_v_src      [STAGES];
  logic [Slice-1:0] w_slice_s    [STAGES];
  logic             w_slice_c    [STAGES];
  logic             w_slice_cmsb [STAGES];
  logic [STAGES-1:0] w_unused_stage;
  logic             w_unused;
  logic             w_adv;
  stage_t           w_last;

  assign w_last = r_stage[STAGES-1];
  assign w_adv  = !w_last.v || bus.out_ready;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_a_src[k] = bus.a;
      assign w_b_src[k] = bus.b;
      assign w_s_src[k] = '0;
      assign w_c_src[k] = bus.cin;
      assign w_v_src[k] = bus.in_valid;
    end else begin : g_body
      assign w_a_src[k] = r_stage[k-1].a[WIDTH-1:0];
      assign w_b_src[k] = r_stage[k-1].b[WIDTH-1:0];
      assign w_s_src[k] = r_stage[k-1].s[WIDTH-1:0];
      assign w_c_src[k] = r_stage[k-1].c;
      assign w_v_src[k] = r_stage[k-1].v;
    end

    add_slice #(
      .Width (Slice)
    ) u_add_slice (
      .i_a    (w_a_src[k][k*Slice +: Slice]),
      .i_b    (w_b_src[k][k*Slice +: Slice]),
      .i_cin  (w_c_src[k]),
      .o_s    (w_slice_s[k]),
      .o_cout (w_slice_c[k]),
      .o_cmsb (w_slice_cmsb[k])
    );

    // Consumed operand bits and the full last-stage operands are dead by design.
    assign w_unused_stage[k] = ^{r_stage[k], w_slice_cmsb[k]};
  end

  assign w_unused = ^w_unused_stage;

  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      w_next[k]                      = '0;
      w_next[k].a[WIDTH-1:0]         = w_a_src[k];
      w_next[k].b[WIDTH-1:0]         = w_b_src[k];
      w_next[k].s[WIDTH-1:0]         = w_s_src[k];
      w_next[k].s[k*Slice +: Slice]  = w_slice_s[k];
      w_next[k].c                    = w_slice_c[k];
      w_next[k].v                    = w_v_src[k];
`ifdef PIPE_ADD_OVF_EN
      if (k == int'(STAGES) - 1) w_next[k].msb_c = w_slice_cmsb[k];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) r_stage[k] <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < int'(STAGES); k++) r_stage[k] <= w_next[k];
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = w_last.v;
  assign bus.sum       = w_last.s[WIDTH-1:0];
  assign bus.cout      = w_last.c;
`ifdef PIPE_ADD_OVF_EN
  assign bus.ovf       = w_last.msb_c ^ w_last.c;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: 16-bit/4-stage instance plus an 8-bit/1-stage instance.
module tb_pipelined_adder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  pipelined_adder_if #(.WIDTH(16)) bus  ();
  pipelined_adder_if #(.WIDTH(8))  bus1 ();

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  logic [15:0] b2b_sum [8] = '{16'h0000, 16'h1002, 16'h2002, 16'h3004,
                               16'h4004, 16'h5006, 16'h6006, 16'h7008};
  logic [15:0] st_a    [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
  logic [15:0] st_sum  [5] = '{16'h1112, 16'h2223, 16'h3334, 16'h4445, 16'h5556};
  int          st_idx  [13] = '{-1, -1, -1, -1, 0, 0, 0, 0, 1, 2, 3, 4, -1};

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic c);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (6) next_slot();
  endtask

  // Sends one beat from a slot start and reports edges-after-accept until out_valid.
  task automatic one_beat(input logic [15:0] a, input logic [15:0] b, input logic c,
                          output int lat, output logic [15:0] s, output logic co,
                          output logic ov);
    lat = -1;
    s   = 'x;
    co  = 1'bx;
    ov  = 1'bx;
    drive(1'b1, a, b, c);
    next_slot();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = n - 1;
        s   = bus.sum;
        co  = bus.cout;
`ifdef PIPE_ADD_OVF_EN
        ov  = bus.ovf;
`else
        ov  = 1'b0;
`endif
      end
      next_slot();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    bus.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.a         = 8'h0;
    bus1.b         = 8'h0;
    bus1.cin       = 1'b0;
    bus1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    total++;
    if (bus.sum !== 16'h0 || bus.cout !== 1'b0) begin
      bad++; $display("FAIL reset_sum: got %h/%b want 0000/0", bus.sum, bus.cout);
    end
`ifdef PIPE_ADD_OVF_EN
    total++;
    if (bus.ovf !== 1'b0) begin
      bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf);
    end
`endif
    #2 rst_n = 1'b1;
    next_slot();
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset: in_ready=%b out_valid=%b want 1/0",
                      bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_carry_chain();
    int lat;
    logic [15:0] s;
    logic co, ov;
    idle();
    one_beat(16'hFFFF, 16'h0001, 1'b0, lat, s, co, ov);
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL carry_latency: got %0d want 3", lat);
    end
    total++;
    if (s !== 16'h0000 || co !== 1'b1) begin
      bad++; $display("FAIL carry_chain: got %h/%b want 0000/1", s, co);
    end
`ifdef PIPE_ADD_OVF_EN
    total++;
    if (ov !== 1'b0) begin
      bad++; $display("FAIL carry_ovf: got %b want 0", ov);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    idle();
    for (int s = 0; s < 13; s++) begin
      if (s < 8) drive(1'b1, 16'(s), 16'(s * 4096), 1'(s & 1));
      else       drive(1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_in_ready slot %0d: got %b want 1", s, bus.in_ready);
      end
      exp_v = (s >= 4 && s < 12);
      total++;
      if (bus.out_valid !== exp_v) begin
        bad++; $display("FAIL b2b_valid slot %0d: got %b want %b", s, bus.out_valid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (bus.sum !== b2b_sum[s-4] || bus.cout !== 1'b0) begin
          bad++; $display("FAIL b2b_sum slot %0d: got %h/%b want %h/0",
                          s, bus.sum, bus.cout, b2b_sum[s-4]);
        end
      end
      next_slot();
    end
  endtask

  task automatic test_stall();
    logic exp_rdy, exp_v;
    idle();
    for (int s = 0; s < 13; s++) begin
      bus.out_ready = !(s >= 4 && s <= 6);
      if (s <= 3)      drive(1'b1, st_a[s], 16'h0001, 1'b0);
      else if (s <= 7) drive(1'b1, st_a[4], 16'h0001, 1'b0);
      else             drive(1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      exp_rdy = !(s >= 4 && s <= 6);
      exp_v   = (st_idx[s] >= 0);
      total++;
      if (bus.in_ready !== exp_rdy) begin
        bad++; $display("FAIL stall_in_ready slot %0d: got %b want %b", s, bus.in_ready,
                        exp_rdy);
      end
      total++;
      if (bus.out_valid !== exp_v) begin
        bad++; $display("FAIL stall_valid slot %0d: got %b want %b", s, bus.out_valid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (bus.sum !== st_sum[st_idx[s]] || bus.cout !== 1'b0) begin
          bad++; $display("FAIL stall_sum slot %0d: got %h/%b want %h/0",
                          s, bus.sum, bus.cout, st_sum[st_idx[s]]);
        end
      end
      next_slot();
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    int lat;
    logic [15:0] s;
    logic co, ov;
    idle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(16 * (i + 1)), 16'h0, 1'b0);
      next_slot();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0010) begin
      bad++; $display("FAIL pre_reset: got %b/%h want 1/0010", bus.out_valid, bus.sum);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0) begin
      bad++; $display("FAIL async_reset: got %b/%h want 0/0000", bus.out_valid, bus.sum);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL stale_after_reset cycle %0d: got %b want 0", i, bus.out_valid);
      end
    end
    next_slot();
    one_beat(16'h1234, 16'h4321, 1'b1, lat, s, co, ov);
    total++;
    if (lat !== 3 || s !== 16'h5556 || co !== 1'b0) begin
      bad++; $display("FAIL reset_recover: got lat=%0d %h/%b want lat=3 5556/0", lat, s, co);
    end
  endtask

`ifdef PIPE_ADD_OVF_EN
  task automatic test_ovf();
    int lat;
    logic [15:0] s;
    logic co, ov;
    idle();
    one_beat(16'h7FFF, 16'h0001, 1'b0, lat, s, co, ov);
    total++;
    if (lat !== 3 || s !== 16'h8000 || co !== 1'b0 || ov !== 1'b1) begin
      bad++; $display("FAIL ovf_pos: got lat=%0d %h/%b/%b want 3 8000/0/1", lat, s, co, ov);
    end
    one_beat(16'hFFFF, 16'h0001, 1'b0, lat, s, co, ov);
    total++;
    if (lat !== 3 || s !== 16'h0000 || co !== 1'b1 || ov !== 1'b0) begin
      bad++; $display("FAIL ovf_wrap: got lat=%0d %h/%b/%b want 3 0000/1/0", lat, s, co, ov);
    end
    one_beat(16'h8000, 16'h8000, 1'b0, lat, s, co, ov);
    total++;
    if (lat !== 3 || s !== 16'h0000 || co !== 1'b1 || ov !== 1'b1) begin
      bad++; $display("FAIL ovf_neg: got lat=%0d %h/%b/%b want 3 0000/1/1", lat, s, co, ov);
    end
  endtask
`endif

  task automatic test_single_stage();
    idle();
    bus1.in_valid = 1'b1;
    bus1.a        = 8'hA5;
    bus1.b        = 8'h5A;
    bus1.cin      = 1'b1;
    @(negedge clk);
    total++;
    if (bus1.out_valid !== 1'b0) begin
      bad++; $display("FAIL s1_before: got %b want 0", bus1.out_valid);
    end
    next_slot();
    bus1.a   = 8'h12;
    bus1.b   = 8'h34;
    bus1.cin = 1'b0;
    @(negedge clk);
    total++;
    if (bus1.out_valid !== 1'b1 || bus1.sum !== 8'h00 || bus1.cout !== 1'b1) begin
      bad++; $display("FAIL s1_first: got %b/%h/%b want 1/00/1", bus1.out_valid, bus1.sum,
                      bus1.cout);
    end
    next_slot();
    bus1.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus1.out_valid !== 1'b1 || bus1.sum !== 8'h46 || bus1.cout !== 1'b0) begin
      bad++; $display("FAIL s1_second: got %b/%h/%b want 1/46/0", bus1.out_valid, bus1.sum,
                      bus1.cout);
    end
    next_slot();
    @(negedge clk);
    total++;
    if (bus1.out_valid !== 1'b0) begin
      bad++; $display("FAIL s1_drain: got %b want 0", bus1.out_valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_carry_chain();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
`ifdef PIPE_ADD_OVF_EN
    test_ovf();
`endif
    test_single_stage();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
